// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one synchronous-read unified memory between the fetch
// stage and the memory stage. At most one requester is granted per cycle.
// Data accesses normally win, but a starvation counter guarantees that fetch
// is granted after STARVE_MAX consecutive denials. The read response arrives
// one cycle after the grant and is steered back to the requester that issued
// it by a small response tag register.
module mem_port_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    // Fetch (instruction read) port
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_gnt,
    output logic        o_if_hold,
    output logic        o_if_rvld,
    output logic [31:0] o_if_rdata,

    // Data (load/store) port
    input  logic        i_d_ren,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_gnt,
    output logic        o_d_stall,
    output logic        o_d_rvld,
    output logic [31:0] o_d_rdata,

    // Unified memory port
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_rdata
);

    // Who owns the read data arriving from memory this cycle.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_src_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    resp_src_t   resp_src_r;
    logic [3:0]  starve_cnt_r;

    logic        d_req_s;
    logic        d_store_s;
    logic        starve_hit_s;
    logic        if_gnt_s;
    logic        d_gnt_s;
    logic        unused_addr_lsb_s;

    // Word addressing: the two byte-offset bits of both request addresses
    // never reach memory.
    assign unused_addr_lsb_s = ^{i_if_addr[1:0], i_d_addr[1:0]};

    // A store wins over a load if both strobes are raised together.
    assign d_req_s      = i_d_ren | i_d_wen;
    assign d_store_s    = i_d_wen;
    assign starve_hit_s = (starve_cnt_r == STARVE_LIM);

    // Arbitration: data first, fetch only when alone or when starved.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (i_rst) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (i_if_req && (!d_req_s || starve_hit_s)) begin
            if_gnt_s = 1'b1;
        end else if (d_req_s) begin
            d_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    assign o_if_gnt  = if_gnt_s;
    assign o_d_gnt   = d_gnt_s;
    // Hold/stall are silenced during reset so every output reads zero.
    assign o_if_hold = i_if_req & ~if_gnt_s & ~i_rst;
    assign o_d_stall = d_req_s  & ~d_gnt_s  & ~i_rst;

    // Memory port drive: granted requester's address and strobes, zero when idle.
    always_comb begin
        o_mem_addr  = 32'h0000_0000;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = 32'h0000_0000;
        o_mem_mask  = 4'b0000;
        if (if_gnt_s) begin
            o_mem_addr = {i_if_addr[31:2], 2'b00};
            o_mem_ren  = 1'b1;
        end else if (d_gnt_s) begin
            o_mem_addr = {i_d_addr[31:2], 2'b00};
            if (d_store_s) begin
                o_mem_wen   = 1'b1;
                o_mem_wdata = i_d_wdata;
                o_mem_mask  = i_d_mask;
            end else begin
                o_mem_ren = 1'b1;
            end
        end else begin
            o_mem_addr = 32'h0000_0000;
        end
    end

    // Response steering: memory read data goes to the tagged owner, others see zero.
    always_comb begin
        o_if_rvld  = 1'b0;
        o_if_rdata = 32'h0000_0000;
        o_d_rvld   = 1'b0;
        o_d_rdata  = 32'h0000_0000;
        if (i_rst) begin
            o_if_rvld = 1'b0;
            o_d_rvld  = 1'b0;
        end else begin
            case (resp_src_r)
                RESP_IF: begin
                    o_if_rvld  = 1'b1;
                    o_if_rdata = i_mem_rdata;
                end
                RESP_D: begin
                    o_d_rvld  = 1'b1;
                    o_d_rdata = i_mem_rdata;
                end
                RESP_NONE: begin
                    o_if_rvld = 1'b0;
                    o_d_rvld  = 1'b0;
                end
                default: begin
                    o_if_rvld = 1'b0;
                    o_d_rvld  = 1'b0;
                end
            endcase
        end
    end

    // Response tag: remember which read was issued; flushed fetches and stores leave none.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            resp_src_r <= RESP_NONE;
        end else if (if_gnt_s && !i_if_flush) begin
            resp_src_r <= RESP_IF;
        end else if (d_gnt_s && !d_store_s) begin
            resp_src_r <= RESP_D;
        end else begin
            resp_src_r <= RESP_NONE;
        end
    end

    // Starvation counter: counts consecutive fetch denials, saturating at the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_r <= 4'd0;
        end else if (!i_if_req || if_gnt_s) begin
            starve_cnt_r <= 4'd0;
        end else if (!starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a synchronous RAM model feeds the DUT, a reference
// model predicts grants and read responses, and a monitor pops predicted
// responses from queues whenever the DUT signals a valid response.
module tb_mem_port_arb;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_ren, d_wen;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_mask;
    logic        if_gnt, if_hold, if_rvld, d_gnt, d_stall, d_rvld;
    logic [31:0] if_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;
    logic [3:0]  mem_mask;

    always #5 clk = ~clk;

    mem_port_arb #(.STARVE_MAX(SM)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_hold(if_hold), .o_if_rvld(if_rvld), .o_if_rdata(if_rdata),
        .i_d_ren(d_ren), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_mask(d_mask), .o_d_gnt(d_gnt), .o_d_stall(d_stall), .o_d_rvld(d_rvld),
        .o_d_rdata(d_rdata),
        .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
        .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask), .i_mem_rdata(mem_rdata)
    );

    // Initial memory image: index 0x80 (byte 0x200) is zero for the store test.
    function automatic logic [31:0] seed(input int i);
        logic [31:0] v;
        v = (i == 32'h80) ? 32'h0 : ((i * 32'h9E37_79B1) ^ 32'hA5A5_0000);
        return v;
    endfunction

    // Synchronous-read RAM attached to the memory port.
    logic [31:0] ram [0:1023];
    logic [31:0] ram_q = 32'h0;
    bit          ram_init = 1'b0;
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= seed(i);
            ram_init <= 1'b1;
        end else begin
            if (mem_ren) ram_q <= ram[mem_addr[11:2]];
            if (mem_wen)
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state
    typedef struct { int due; logic [31:0] data; } resp_t;
    resp_t       if_q[$];
    resp_t       d_q[$];
    logic [31:0] mdl [0:1023];
    int          denials;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare combinational outputs, advance the model.
    task automatic step(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                        input logic rn, input logic wn, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] mk,
                        output logic eig, output logic edg);
        logic dreq;
        logic [31:0] w;
        @(posedge clk); #1;
        cyc++;
        rst = r; if_req = ir; if_addr = ia; if_flush = fl;
        d_ren = rn; d_wen = wn; d_addr = da; d_wdata = wd; d_mask = mk;
        #1;
        dreq = rn | wn;
        if (r) begin
            eig = 1'b0; edg = 1'b0;
            if_q.delete(); d_q.delete();
            check("rst_flags", {if_gnt, if_hold, if_rvld, d_gnt, d_stall, d_rvld, mem_ren, mem_wen}, 32'h0);
            check("rst_addr", mem_addr, 32'h0);
            check("rst_wdata", mem_wdata, 32'h0);
            check("rst_mask", {28'h0, mem_mask}, 32'h0);
            check("rst_rdata", if_rdata | d_rdata, 32'h0);
            denials = 0;
        end else begin
            // Fetch wins when alone or after SM consecutive denials.
            eig = ir && (!dreq || denials == SM);
            edg = dreq && !eig;
            check("if_gnt", if_gnt, eig);
            check("d_gnt", d_gnt, edg);
            check("if_hold", if_hold, ir && !eig);
            check("d_stall", d_stall, dreq && !edg);
            check("mem_ren", mem_ren, eig || (edg && !wn));
            check("mem_wen", mem_wen, edg && wn);
            if (eig) check("mem_addr_if", mem_addr, {ia[31:2], 2'b00});
            if (edg) check("mem_addr_d", mem_addr, {da[31:2], 2'b00});
            if (edg && wn) begin
                check("mem_wdata", mem_wdata, wd);
                check("mem_mask", {28'h0, mem_mask}, {28'h0, mk});
            end
            if (eig && !fl) if_q.push_back('{cyc + 1, mdl[ia[11:2]]});
            if (edg && !wn) d_q.push_back('{cyc + 1, mdl[da[11:2]]});
            if (edg && wn) begin
                w = mdl[da[11:2]];
                for (int b = 0; b < 4; b++) if (mk[b]) w[8*b +: 8] = wd[8*b +: 8];
                mdl[da[11:2]] = w;
            end
            if (!ir || eig) denials = 0;
            else if (denials < SM) denials++;
        end
    endtask

    // Response monitor: each cycle, a response is expected exactly when one is due.
    always @(negedge clk) begin
        resp_t r;
        logic  due;
        due = (if_q.size() > 0) && (if_q[0].due == cyc);
        check("if_rvld", if_rvld, due);
        if (due) begin r = if_q.pop_front(); check("if_rdata", if_rdata, r.data); end
        else check("if_rdata_zero", if_rdata, 32'h0);
        due = (d_q.size() > 0) && (d_q[0].due == cyc);
        check("d_rvld", d_rvld, due);
        if (due) begin r = d_q.pop_front(); check("d_rdata", d_rdata, r.data); end
        else check("d_rdata_zero", d_rdata, 32'h0);
    end

    initial begin
        logic eg, dg;
        logic p_if, p_d, p_rn, p_wn, fl, rs;
        logic [31:0] p_ia, p_da, p_wd;
        logic [3:0]  p_mk;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_ren = 1'b0; d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_mask = 4'h0;
        denials = 0;
        for (int i = 0; i < 1024; i++) mdl[i] = seed(i);

        // Reset, then one idle cycle
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);

        // Back-to-back fetches 0x0, 0x4, 0x8
        step(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, eg, dg);
        step(0, 1, 32'h4, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_fetch_rdata0", if_rdata, seed(0));
        step(0, 1, 32'h8, 0, 0, 0, 0, 0, 0, eg, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_fetch_rdata2", if_rdata, seed(2));

        // Contested load 0x100 vs fetch 0x10
        step(0, 1, 32'h10, 0, 1, 0, 32'h100, 0, 0, eg, dg);
        check("dir_contest_hold", if_hold, 1'b1);
        step(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_contest_drdata", d_rdata, seed(32'h40));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_contest_irdata", if_rdata, seed(4));

        // Starvation: fetch denied SM cycles, granted on the next
        for (int k = 1; k <= SM + 1; k++) begin
            step(0, 1, 32'h20, 0, 1, 0, 32'h30, 0, 0, eg, dg);
            check("dir_starve_gnt", if_gnt, (k == SM + 1));
            check("dir_starve_stall", d_stall, (k == SM + 1));
        end
        step(0, 1, 32'h24, 0, 1, 0, 32'h30, 0, 0, eg, dg);
        check("dir_starve_cleared", if_gnt, 1'b0);
        step(0, 1, 32'h24, 0, 0, 0, 0, 0, 0, eg, dg);

        // Masked store then load over zeroed word
        step(0, 0, 0, 0, 0, 1, 32'h200, 32'hDEADBEEF, 4'b0011, eg, dg);
        check("dir_store_mask", {28'h0, mem_mask}, 32'h3);
        step(0, 0, 0, 0, 1, 0, 32'h200, 0, 0, eg, dg);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_load_beef", d_rdata, 32'h0000BEEF);

        // Flushed fetch drops its response; the next fetch responds
        step(0, 1, 32'h40, 1, 0, 0, 0, 0, 0, eg, dg);
        step(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_flush_drop", if_rvld, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        check("dir_flush_next", if_rvld, 1'b1);

        // Reset while load response pending
        step(0, 0, 0, 0, 1, 0, 32'h100, 0, 0, eg, dg);
        step(1, 1, 32'h0, 0, 1, 0, 32'h100, 0, 0, eg, dg);
        check("dir_rst_drop", d_rvld, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);

        // Randomized traffic; requesters hold their request until granted
        p_if = 0; p_d = 0; p_ia = 0; p_da = 0; p_wd = 0; p_mk = 0; p_rn = 0; p_wn = 0;
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 9) == 0);
            if (!p_if || fl) begin
                p_if = ($urandom_range(0, 9) < 7);
                p_ia = $urandom & 32'h0000_03FF;
            end
            if (!p_d) begin
                p_d  = ($urandom_range(0, 1) == 1);
                p_wn = ($urandom_range(0, 9) < 4);
                p_rn = !p_wn || ($urandom_range(0, 19) == 0);
                p_da = $urandom & 32'h0000_03FF;
                p_wd = $urandom;
                p_mk = 4'($urandom);
            end
            step(rs, p_if, p_ia, fl, p_d & p_rn, p_d & p_wn, p_da, p_wd, p_mk, eg, dg);
            if (rs || eg) p_if = 0;
            if (rs || dg) p_d = 0;
        end

        for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, eg, dg);
        check("drain_empty", if_q.size() + d_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Single-port memory arbiter that shares one synchronous-read unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores). Each cycle it grants at most one requester, routes the one-cycle-latency read response back to the requester that issued it, and drives the fetch stage's hold input whenever fetch loses arbitration. Data accesses have priority; a starvation counter bounds how long fetch can be locked out.

## Interface
- STARVE_MAX, default 4: consecutive fetch denials after which fetch wins the next contested cycle (legal range 1–15).
- i_clk  in  1  global clock; all state updates on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_if_req  in  1  fetch requests an instruction read this cycle.
- i_if_addr  in  32  fetch word address (byte address, bits [1:0] ignored).
- i_if_flush  in  1  fetch redirect; discard any fetch response due next cycle.
- o_if_gnt  out  1  fetch read issued to memory this cycle.
- o_if_hold  out  1  i_if_req & !o_if_gnt; fetch must hold PC and IF/ID register.
- o_if_rvld  out  1  o_if_rdata valid (cycle after a fetch grant).
- o_if_rdata  out  32  instruction word.
- i_d_ren  in  1  load request.
- i_d_wen  in  1  store request (i_d_ren & i_d_wen is illegal; treated as store).
- i_d_addr  in  32  data byte address, bits [1:0] ignored.
- i_d_wdata  in  32  store data.
- i_d_mask  in  4  store byte enables.
- o_d_gnt  out  1  data access issued this cycle.
- o_d_stall  out  1  (i_d_ren | i_d_wen) & !o_d_gnt.
- o_d_rvld  out  1  o_d_rdata valid (cycle after a load grant).
- o_d_rdata  out  32  load word.
- o_mem_addr  out  32  address to memory, bits [1:0] forced 0.
- o_mem_ren  out  1  memory read strobe.
- o_mem_wen  out  1  memory write strobe.
- o_mem_wdata  out  32  write data.
- o_mem_mask  out  4  write byte enables.
- i_mem_rdata  in  32  read data, valid one cycle after o_mem_ren.

## Operation
- Grant logic combinational from current requests and starve counter; at most one of o_if_gnt/o_d_gnt high.
- Priority: data request only → data; fetch only → fetch; both → data, unless starve_cnt == STARVE_MAX, then fetch.
- starve_cnt (4-bit): reset 0; +1 when fetch requests and is denied (saturates at STARVE_MAX); cleared when fetch granted or i_if_req low.
- Memory drive: granted requester's address; o_mem_ren for fetch or load, o_mem_wen + wdata/mask for store; all strobes 0 when idle. Address/data outputs are don't-care when idle but must be 0 under reset.
- Response tag register resp_src, states NONE/IF/D: next = IF on fetch grant, D on load grant, NONE otherwise (stores and idle → NONE).
- resp_src == IF: o_if_rvld=1 unless i_if_flush was high in the grant cycle (flush latched into resp_src as NONE); o_if_rdata = i_mem_rdata.
- resp_src == D: o_d_rvld=1, o_d_rdata = i_mem_rdata.
- rdata outputs are zero when corresponding rvld is 0.
- i_if_flush with same-cycle i_if_req: new fetch request is still arbitrated normally (redirect target); only the response due next cycle is dropped.

## Timing
- Reset: resp_src=NONE, starve_cnt=0; all outputs 0 in the reset cycle and first cycle after (grants forced 0 while i_rst high).
- Grant-to-response latency: exactly 1 cycle; back-to-back grants every cycle supported (full throughput, one access/cycle).
- Store completes in grant cycle; no response.
- Reset asserted while response pending: response dropped, rvld 0 next cycle.
- Hold/stall are same-cycle combinational; requesters keep address/data stable until granted.
- Fetch worst-case wait under continuous data traffic: STARVE_MAX cycles, granted on cycle STARVE_MAX+1.

## Test plan
- Reset then fetch-only, addr 0x0,0x4,0x8 consecutive: o_if_gnt=1 each cycle, o_if_rvld=1 one cycle later with mem words, o_if_hold=0.
- Simultaneous load 0x100 and fetch 0x10: cycle 0 o_d_gnt=1, o_if_hold=1; cycle 1 o_d_rvld with mem[0x100], o_if_gnt=1; cycle 2 o_if_rvld mem[0x10].
- Continuous data requests + fetch, STARVE_MAX=4: fetch denied 4 cycles, granted 5th, o_d_stall=1 that cycle, starve_cnt returns 0.
- Store 0x200 data 0xDEADBEEF mask 4'b0011 then load 0x200: o_mem_wen with mask 0011, no rvld; load returns 0x0000BEEF over prior-zero memory.
- Fetch grant with i_if_flush=1 same cycle: next cycle o_if_rvld=0; fetch granted next cycle with flush low responds normally.
- i_rst asserted in cycle after load grant: o_d_rvld=0, all strobes 0, starve_cnt=0 after release.
